// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiply sequencer.
package matmul_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned MATMUL_DATA_W = 16;
    localparam int unsigned MATMUL_ACC_W  = 40;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StWaitA,
        StRdB,
        StWaitB,
        StMac,
        StWrC,
        StDone
    } ctrl_state_t;

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate unit with synchronous clear and enable.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = MATMUL_DATA_W,
    parameter int unsigned ACC_W  = MATMUL_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    // Low bits of acc + a*b, i.e. the writeback value once this MAC step commits
    output logic [DATA_W-1:0] sum_o
);

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;

    // Sign-extend operands; the low 2*DATA_W bits of the product are then the signed product
    always_comb begin
        a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
        b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
        prod  = a_ext * b_ext;
        acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        sum_o = acc_d[DATA_W-1:0];
    end

    // Accumulator register; overflow beyond ACC_W wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B over a shared single-port word memory.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = MATMUL_DATA_W,
    parameter int unsigned ACC_W  = MATMUL_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] matrix_a_addr_i,
    input  logic [ADDR_W-1:0] matrix_b_addr_i,
    input  logic [ADDR_W-1:0] matrix_c_addr_i,
    input  logic [15:0]       m_i,
    input  logic [15:0]       n_i,
    input  logic [15:0]       p_i,
    output logic              end_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    ctrl_state_t       state_q;
    logic [15:0]       m_q, n_q, p_q;
    logic [15:0]       i_q, j_q, k_q;
    logic [ADDR_W-1:0] a_row_q, a_ptr_q, b_base_q, b_ptr_q, c_ptr_q;
    logic [DATA_W-1:0] a_op_q, b_op_q;
    logic [DATA_W-1:0] mac_sum;
    logic              mac_clear;
    logic              mac_en;

    // Accumulator clears on run acceptance and after each C element is written
    always_comb begin
        mac_clear = 1'b0;
        if (state_q == StIdle && start_i) begin
            mac_clear = 1'b1;
        end
        if (state_q == StWrC && mem_gnt_i) begin
            mac_clear = 1'b1;
        end
        mac_en = (state_q == StMac);
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear_i (mac_clear),
        .en_i    (mac_en),
        .a_i     (a_op_q),
        .b_i     (b_op_q),
        .sum_o   (mac_sum)
    );

    // Control FSM; memory outputs are loaded on entry to a request state and held until grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            end_o       <= 1'b0;
            busy_o      <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            m_q         <= '0;
            n_q         <= '0;
            p_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_row_q     <= '0;
            a_ptr_q     <= '0;
            b_base_q    <= '0;
            b_ptr_q     <= '0;
            c_ptr_q     <= '0;
            a_op_q      <= '0;
            b_op_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        busy_o   <= 1'b1;
                        m_q      <= m_i;
                        n_q      <= n_i;
                        p_q      <= p_i;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                        a_row_q  <= matrix_a_addr_i;
                        a_ptr_q  <= matrix_a_addr_i;
                        b_base_q <= matrix_b_addr_i;
                        b_ptr_q  <= matrix_b_addr_i;
                        c_ptr_q  <= matrix_c_addr_i;
                        if (m_i == '0 || n_i == '0 || p_i == '0) begin
                            end_o   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= matrix_a_addr_i;
                            state_q    <= StRdA;
                        end
                    end
                end
                StRdA: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= StWaitA;
                    end
                end
                StWaitA: begin
                    if (mem_rvalid_i) begin
                        a_op_q     <= mem_rdata_i;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= b_ptr_q;
                        state_q    <= StRdB;
                    end
                end
                StRdB: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= StWaitB;
                    end
                end
                StWaitB: begin
                    if (mem_rvalid_i) begin
                        b_op_q  <= mem_rdata_i;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    if (k_q != n_q - 16'd1) begin
                        k_q        <= k_q + 16'd1;
                        a_ptr_q    <= a_ptr_q + 16'd1;
                        b_ptr_q    <= b_ptr_q + p_q;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= a_ptr_q + 16'd1;
                        state_q    <= StRdA;
                    end else begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= c_ptr_q;
                        mem_wdata_o <= mac_sum;
                        state_q     <= StWrC;
                    end
                end
                StWrC: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        c_ptr_q   <= c_ptr_q + 16'd1;
                        k_q       <= '0;
                        if (j_q != p_q - 16'd1) begin
                            // Next column in the same row of C
                            j_q        <= j_q + 16'd1;
                            a_ptr_q    <= a_row_q;
                            b_ptr_q    <= b_base_q + j_q + 16'd1;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= a_row_q;
                            state_q    <= StRdA;
                        end else if (i_q != m_q - 16'd1) begin
                            // First column of the next row of C
                            i_q        <= i_q + 16'd1;
                            j_q        <= '0;
                            a_row_q    <= a_row_q + n_q;
                            a_ptr_q    <= a_row_q + n_q;
                            b_ptr_q    <= b_base_q;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= a_row_q + n_q;
                            state_q    <= StRdA;
                        end else begin
                            end_o   <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    end_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl with a behavioural memory and matrix model.
module tb_matmul_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] matrix_a_addr_i = '0;
    logic [15:0] matrix_b_addr_i = '0;
    logic [15:0] matrix_c_addr_i = '0;
    logic [15:0] m_i = '0;
    logic [15:0] n_i = '0;
    logic [15:0] p_i = '0;
    logic        end_o;
    logic        busy_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [15:0] mem_rdata_i;

    matmul_ctrl u_dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .matrix_a_addr_i (matrix_a_addr_i),
        .matrix_b_addr_i (matrix_b_addr_i),
        .matrix_c_addr_i (matrix_c_addr_i),
        .m_i             (m_i),
        .n_i             (n_i),
        .p_i             (p_i),
        .end_o           (end_o),
        .busy_o          (busy_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Memory model state
    logic [15:0] mem [0:65535];
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] rd_addr_q[$];
    int          end_cnt = 0;
    int          req_cnt = 0;
    int          stab_viol = 0;
    int          gnt_dly = 0;
    int          rv_dly = 1;
    bit          gnt_rand = 1'b0;
    bit          rv_rand = 1'b0;

    // Memory responder: decides grant/rvalid at each falling edge, checks request stability
    initial begin : responder
        bit          pending;
        int          wait_cnt;
        int          cur_gdly;
        int          rv_cnt;
        logic [15:0] rv_data;
        logic        held_we;
        logic [15:0] held_addr;
        logic [15:0] held_wdata;
        pending = 1'b0;
        wait_cnt = 0;
        cur_gdly = 0;
        rv_cnt = 0;
        rv_data = '0;
        held_we = 1'b0;
        held_addr = '0;
        held_wdata = '0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            if (end_o) end_cnt++;
            if (reset) begin
                pending = 1'b0;
                rv_cnt = 0;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i = rv_data;
                    end
                end
                if (mem_req_o) begin
                    req_cnt++;
                    if (!pending) begin
                        pending = 1'b1;
                        wait_cnt = 0;
                        cur_gdly = gnt_rand ? int'($urandom_range(3, 0)) : gnt_dly;
                        held_we = mem_we_o;
                        held_addr = mem_addr_o;
                        held_wdata = mem_wdata_o;
                    end else if (mem_we_o !== held_we || mem_addr_o !== held_addr ||
                                 (held_we && mem_wdata_o !== held_wdata)) begin
                        stab_viol++;
                    end
                    if (wait_cnt >= cur_gdly) begin
                        mem_gnt_i = 1'b1;
                        pending = 1'b0;
                        if (mem_we_o) begin
                            wr_addr_q.push_back(mem_addr_o);
                            wr_data_q.push_back(mem_wdata_o);
                        end else begin
                            rd_addr_q.push_back(mem_addr_o);
                            rv_data = mem[mem_addr_o];
                            rv_cnt = rv_rand ? int'($urandom_range(3, 1)) : rv_dly;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic zero_wait();
        gnt_rand = 1'b0;
        rv_rand = 1'b0;
        gnt_dly = 0;
        rv_dly = 1;
    endtask

    task automatic fill(input logic [15:0] base, input int cnt);
        for (int q = 0; q < cnt; q++) begin
            mem[base + 16'(q)] = 16'($urandom);
        end
    endtask

    // Launches one run; cycles = clock edges from the start edge to the edge that raised end_o
    task automatic run_mm(input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] cb,
                          input int mm, input int nn, input int pp, input int restart_at,
                          output int cycles, output bit timed_out, output logic busy_start,
                          output logic busy_after);
        @(negedge clk);
        matrix_a_addr_i = ab;
        matrix_b_addr_i = bb;
        matrix_c_addr_i = cb;
        m_i = 16'(mm);
        n_i = 16'(nn);
        p_i = 16'(pp);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        busy_start = busy_o;
        // Inputs are sampled only at the start edge, so scramble them afterwards
        matrix_a_addr_i = 16'($urandom);
        matrix_b_addr_i = 16'($urandom);
        matrix_c_addr_i = 16'($urandom);
        n_i = 16'($urandom);
        p_i = 16'($urandom);
        cycles = 0;
        timed_out = 1'b1;
        if (end_o) begin
            timed_out = 1'b0;
        end else begin
            for (int c = 1; c <= 20000; c++) begin
                if (c == restart_at) begin
                    m_i = 16'd5;
                    start_i = 1'b1;
                end
                @(posedge clk);
                #1;
                start_i = 1'b0;
                if (end_o) begin
                    cycles = c;
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        busy_after = busy_o;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], row-major, written in row-major order
    task automatic check_writes(input string name, input logic [15:0] ab, input logic [15:0] bb,
                                input logic [15:0] cb, input int mm, input int nn, input int pp,
                                input int w0);
        int nw;
        nw = wr_addr_q.size() - w0;
        vecs++;
        if (nw != mm * pp) begin
            errs++;
            $display("FAIL %s_write_count: got %0d writes, expected %0d", name, nw, mm * pp);
        end else begin
            for (int i = 0; i < mm; i++) begin
                for (int j = 0; j < pp; j++) begin
                    longint      acc;
                    logic [15:0] av, bv, ea, ed;
                    int          idx;
                    acc = 0;
                    for (int k = 0; k < nn; k++) begin
                        av = mem[ab + 16'(i * nn + k)];
                        bv = mem[bb + 16'(k * pp + j)];
                        acc += longint'($signed(av)) * longint'($signed(bv));
                    end
                    ed = acc[15:0];
                    ea = cb + 16'(i * pp + j);
                    idx = w0 + i * pp + j;
                    vecs++;
                    if (wr_addr_q[idx] !== ea || wr_data_q[idx] !== ed) begin
                        errs++;
                        $display("FAIL %s_c[%0d][%0d]: got addr %h data %h, expected addr %h data %h",
                                 name, i, j, wr_addr_q[idx], wr_data_q[idx], ea, ed);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        vecs++;
        if (end_o !== 1'b0 || busy_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_status: got end %b busy %b, expected 0 0", end_o, busy_o);
        end
        vecs++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_req: got req %b we %b, expected 0 0", mem_req_o, mem_we_o);
        end
        vecs++;
        if (mem_addr_o !== 16'h0 || mem_wdata_o !== 16'h0) begin
            errs++;
            $display("FAIL reset_bus: got addr %h wdata %h, expected 0000 0000",
                     mem_addr_o, mem_wdata_o);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int          cyc, e0, w0;
        bit          to;
        logic        bs, ba;
        logic [15:0] exp_c [4];
        zero_wait();
        mem[16'h0000] = 16'd1;
        mem[16'h0001] = 16'd2;
        mem[16'h0002] = 16'd3;
        mem[16'h0003] = 16'd4;
        mem[16'h0010] = 16'd5;
        mem[16'h0011] = 16'd6;
        mem[16'h0012] = 16'd7;
        mem[16'h0013] = 16'd8;
        exp_c = '{16'd19, 16'd22, 16'd43, 16'd50};
        e0 = end_cnt;
        w0 = wr_addr_q.size();
        run_mm(16'h0000, 16'h0010, 16'h0020, 2, 2, 2, 0, cyc, to, bs, ba);
        vecs++;
        if (to || cyc != 44) begin
            errs++;
            $display("FAIL basic_end_cycle: got %0d (timeout %0b), expected 44", cyc, to);
        end
        vecs++;
        if (bs !== 1'b1 || ba !== 1'b0) begin
            errs++;
            $display("FAIL basic_busy: got start %b after %b, expected 1 0", bs, ba);
        end
        vecs++;
        if (end_cnt - e0 != 1) begin
            errs++;
            $display("FAIL basic_end_count: got %0d, expected 1", end_cnt - e0);
        end
        if (wr_addr_q.size() - w0 == 4) begin
            for (int q = 0; q < 4; q++) begin
                vecs++;
                if (wr_addr_q[w0 + q] !== 16'h0020 + 16'(q) || wr_data_q[w0 + q] !== exp_c[q]) begin
                    errs++;
                    $display("FAIL basic_c%0d: got addr %h data %0d, expected addr %h data %0d",
                             q, wr_addr_q[w0 + q], wr_data_q[w0 + q], 16'h0020 + 16'(q), exp_c[q]);
                end
            end
        end
        check_writes("basic", 16'h0000, 16'h0010, 16'h0020, 2, 2, 2, w0);
    endtask

    task automatic test_zero_dim();
        int   cyc, e0, r0, w0;
        bit   to;
        logic bs, ba;
        zero_wait();
        e0 = end_cnt;
        r0 = req_cnt;
        w0 = wr_addr_q.size();
        run_mm(16'h0400, 16'h0500, 16'h0600, 3, 0, 3, 0, cyc, to, bs, ba);
        vecs++;
        if (to || cyc != 0) begin
            errs++;
            $display("FAIL zero_end_cycle: got %0d (timeout %0b), expected end right after start edge",
                     cyc, to);
        end
        vecs++;
        if (req_cnt != r0 || wr_addr_q.size() != w0) begin
            errs++;
            $display("FAIL zero_no_access: got %0d request cycles, expected 0", req_cnt - r0);
        end
        vecs++;
        if (end_cnt - e0 != 1 || bs !== 1'b1 || ba !== 1'b0) begin
            errs++;
            $display("FAIL zero_end_busy: got ends %0d busy %b/%b, expected 1 and 1/0",
                     end_cnt - e0, bs, ba);
        end
    endtask

    task automatic test_stall();
        int   cyc, s0, w0;
        bit   to;
        logic bs, ba;
        zero_wait();
        gnt_dly = 3;
        rv_dly = 2;
        mem[16'h0100] = 16'd1;
        mem[16'h0101] = 16'hFFFE;
        mem[16'h0102] = 16'd3;
        mem[16'h0200] = 16'd4;
        mem[16'h0201] = 16'd5;
        mem[16'h0202] = 16'd6;
        s0 = stab_viol;
        w0 = wr_addr_q.size();
        run_mm(16'h0100, 16'h0200, 16'h0300, 1, 3, 1, 0, cyc, to, bs, ba);
        // Each k step: 4 (read A) + 2 (rvalid) + 4 + 2 + 1 (MAC); write takes 4
        vecs++;
        if (to || cyc != 43) begin
            errs++;
            $display("FAIL stall_end_cycle: got %0d (timeout %0b), expected 43", cyc, to);
        end
        vecs++;
        if (stab_viol != s0) begin
            errs++;
            $display("FAIL stall_stable: got %0d changes while pending, expected 0", stab_viol - s0);
        end
        check_writes("stall", 16'h0100, 16'h0200, 16'h0300, 1, 3, 1, w0);
    endtask

    task automatic test_start_busy();
        int          cyc, e0, w0;
        bit          to;
        logic        bs, ba;
        logic [15:0] ab, bb, cb;
        zero_wait();
        ab = 16'($urandom);
        bb = 16'($urandom);
        cb = 16'($urandom);
        fill(ab, 6);
        fill(bb, 6);
        e0 = end_cnt;
        w0 = wr_addr_q.size();
        run_mm(ab, bb, cb, 2, 3, 2, 12, cyc, to, bs, ba);
        vecs++;
        if (to || cyc != 64) begin
            errs++;
            $display("FAIL busy_start_cycle: got %0d (timeout %0b), expected 64", cyc, to);
        end
        vecs++;
        if (end_cnt - e0 != 1) begin
            errs++;
            $display("FAIL busy_start_end_count: got %0d, expected 1", end_cnt - e0);
        end
        check_writes("busy_start", ab, bb, cb, 2, 3, 2, w0);
    endtask

    task automatic test_reset_mid();
        int          cyc, e0, w0, mm, nn, pp;
        bit          to, found;
        logic        bs, ba;
        logic [15:0] ab, bb, cb;
        zero_wait();
        rv_dly = 4;
        ab = 16'h1000;
        bb = 16'h2345;
        cb = 16'h3000;
        fill(ab, 4);
        fill(bb, 4);
        e0 = end_cnt;
        w0 = wr_addr_q.size();
        @(negedge clk);
        matrix_a_addr_i = ab;
        matrix_b_addr_i = bb;
        matrix_c_addr_i = cb;
        m_i = 16'd2;
        n_i = 16'd2;
        p_i = 16'd2;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mem_req_o && !mem_we_o && mem_addr_o == bb) begin
                found = 1'b1;
                break;
            end
        end
        vecs++;
        if (!found) begin
            errs++;
            $display("FAIL rstmid_b_read: got no B read within 200 cycles, expected one");
        end
        // Granted B read; the next edge enters the wait-for-rvalid state
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vecs++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || busy_o !== 1'b0 || end_o !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_async: got req %b we %b busy %b end %b, expected 0 0 0 0",
                     mem_req_o, mem_we_o, busy_o, end_o);
        end
        vecs++;
        if (mem_addr_o !== 16'h0 || mem_wdata_o !== 16'h0) begin
            errs++;
            $display("FAIL rstmid_bus: got addr %h wdata %h, expected 0000 0000",
                     mem_addr_o, mem_wdata_o);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (end_cnt != e0 || wr_addr_q.size() != w0) begin
            errs++;
            $display("FAIL rstmid_no_end: got ends %0d writes %0d, expected 0 0",
                     end_cnt - e0, wr_addr_q.size() - w0);
        end
        mm = int'($urandom_range(3, 1));
        nn = int'($urandom_range(3, 1));
        pp = int'($urandom_range(3, 1));
        fill(ab, mm * nn);
        fill(bb, nn * pp);
        zero_wait();
        run_mm(ab, bb, cb, mm, nn, pp, 0, cyc, to, bs, ba);
        vecs++;
        if (to || cyc != mm * pp * (5 * nn + 1)) begin
            errs++;
            $display("FAIL rstmid_rerun_cycle: got %0d (timeout %0b), expected %0d",
                     cyc, to, mm * pp * (5 * nn + 1));
        end
        check_writes("rstmid_rerun", ab, bb, cb, mm, nn, pp, w0);
    endtask

    task automatic test_wrap();
        int   cyc, r0, w0;
        bit   to;
        logic bs, ba;
        zero_wait();
        mem[16'h0100] = 16'd256;
        mem[16'h0101] = 16'd3;
        mem[16'hFFFF] = 16'd256;
        mem[16'h0001] = 16'd1;
        mem[16'h0000] = 16'($urandom);
        mem[16'h0002] = 16'($urandom);
        r0 = rd_addr_q.size();
        w0 = wr_addr_q.size();
        run_mm(16'h0100, 16'hFFFF, 16'h0200, 1, 2, 2, 0, cyc, to, bs, ba);
        vecs++;
        if (rd_addr_q.size() - r0 < 4) begin
            errs++;
            $display("FAIL wrap_reads: got %0d reads, expected at least 4", rd_addr_q.size() - r0);
        end else if (rd_addr_q[r0 + 1] !== 16'hFFFF || rd_addr_q[r0 + 3] !== 16'h0001) begin
            errs++;
            $display("FAIL wrap_reads: got B addrs %h %h, expected ffff 0001",
                     rd_addr_q[r0 + 1], rd_addr_q[r0 + 3]);
        end
        vecs++;
        if (wr_data_q.size() == w0) begin
            errs++;
            $display("FAIL wrap_trunc: got no write, expected data 0003");
        end else if (wr_data_q[w0] !== 16'h0003) begin
            errs++;
            $display("FAIL wrap_trunc: got %h, expected 0003", wr_data_q[w0]);
        end
        check_writes("wrap", 16'h0100, 16'hFFFF, 16'h0200, 1, 2, 2, w0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            int          cyc, e0, w0, s0, mm, nn, pp;
            bit          to;
            logic        bs, ba;
            logic [15:0] ab, bb, cb;
            mm = int'($urandom_range(3, 1));
            nn = int'($urandom_range(3, 1));
            pp = int'($urandom_range(3, 1));
            ab = 16'($urandom);
            bb = 16'($urandom);
            cb = 16'($urandom);
            fill(ab, mm * nn);
            fill(bb, nn * pp);
            zero_wait();
            if (r >= 3) begin
                gnt_rand = 1'b1;
                rv_rand = 1'b1;
            end
            e0 = end_cnt;
            w0 = wr_addr_q.size();
            s0 = stab_viol;
            run_mm(ab, bb, cb, mm, nn, pp, 0, cyc, to, bs, ba);
            vecs++;
            if (to || (r < 3 && cyc != mm * pp * (5 * nn + 1))) begin
                errs++;
                $display("FAIL b2b%0d_end_cycle: got %0d (timeout %0b), expected %0d", r, cyc, to,
                         mm * pp * (5 * nn + 1));
            end
            vecs++;
            if (end_cnt - e0 != 1 || stab_viol != s0) begin
                errs++;
                $display("FAIL b2b%0d_end_stable: got ends %0d unstable %0d, expected 1 0",
                         r, end_cnt - e0, stab_viol - s0);
            end
            check_writes($sformatf("b2b%0d", r), ab, bb, cb, mm, nn, pp, w0);
        end
    endtask

    initial begin : main
        for (int q = 0; q < 65536; q++) begin
            mem[q] = '0;
        end
        test_reset();
        test_basic();
        test_zero_dim();
        test_stall();
        test_start_busy();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
